// File: rtl/spi_target_burst.sv
// SPI mode-0 register-access target with burst auto-increment, fully synchronous to clock.
// spi_clk, cs_n and mosi are oversampled; edges come from the last two synchronizer stages.
module spi_target_burst #(
   parameter int ADDR_W      = 6,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int RD_LAT      = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              spi_clk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic [ADDR_W-1:0] address,
   output logic              write_en,
   output logic [DATA_W-1:0] wr_data,
   output logic              read_en,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              frame_err,
   output logic [7:0]        err_count
);

   localparam int HDR_W = ADDR_W + 2;
   localparam int SH_W  = (HDR_W > DATA_W) ? HDR_W : DATA_W;
   localparam int CNT_W = $clog2(SH_W + 1);
   localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [1:0]       LAT_LAST  = 2'(RD_LAT);

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      HEADER,
      WDATA,
      RFETCH,
      RDATA,
      ERROR
   } state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_reg;
   logic [SYNC_STAGES-1:0] cs_sync_reg;
   logic [SYNC_STAGES-1:0] mosi_sync_reg;

   state_t              state_reg;
   logic [CNT_W-1:0]    bit_cnt_reg;
   logic [1:0]          lat_cnt_reg;
   logic [SH_W-2:0]     shift_in_reg;
   logic [DATA_W-1:0]   shift_out_reg;
   logic                bit_seen_reg;
   logic                incr_pending_reg;
   logic                miso_reg;
   logic [ADDR_W-1:0]   address_reg;
   logic                write_en_reg;
   logic [DATA_W-1:0]   wr_data_reg;
   logic                read_en_reg;
   logic                busy_reg;
   logic                frame_err_reg;
   logic [7:0]          err_count_reg;

   logic                sclk_rise;
   logic                sclk_fall;
   logic                cs_rise;
   logic                cs_fall;
   logic                cs_high;
   logic                mosi_s;
   logic [HDR_W-1:0]    hdr_word;
   logic [DATA_W-1:0]   data_word;
   logic                hdr_ok;
   logic                partial;

   // cs_n synchronizer resets low so a pin held low through reset never looks like a fresh fall.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sclk_sync_reg <= '0;
         cs_sync_reg   <= '0;
         mosi_sync_reg <= '0;
      end else begin
         sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_clk};
         cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], cs_n};
         mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
      end
   end

   assign sclk_rise = sclk_sync_reg[SYNC_STAGES-2] & ~sclk_sync_reg[SYNC_STAGES-1];
   assign sclk_fall = ~sclk_sync_reg[SYNC_STAGES-2] & sclk_sync_reg[SYNC_STAGES-1];
   assign cs_rise   = cs_sync_reg[SYNC_STAGES-2] & ~cs_sync_reg[SYNC_STAGES-1];
   assign cs_fall   = ~cs_sync_reg[SYNC_STAGES-2] & cs_sync_reg[SYNC_STAGES-1];
   assign cs_high   = cs_sync_reg[SYNC_STAGES-2] & cs_sync_reg[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];

   assign hdr_word  = {shift_in_reg[HDR_W-2:0], mosi_s};
   assign data_word = {shift_in_reg[DATA_W-2:0], mosi_s};
   assign hdr_ok    = (hdr_word[HDR_W-2] == ^{hdr_word[HDR_W-1], hdr_word[ADDR_W-1:0]})
                      && (hdr_word != {HDR_W{1'b1}});
   assign partial   = (bit_cnt_reg != '0)
                      && (state_reg == HEADER || state_reg == WDATA || state_reg == RDATA);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg        <= WAIT_IDLE;
         bit_cnt_reg      <= '0;
         lat_cnt_reg      <= '0;
         shift_in_reg     <= '0;
         shift_out_reg    <= '0;
         bit_seen_reg     <= 1'b0;
         incr_pending_reg <= 1'b0;
         miso_reg         <= 1'b1;
         address_reg      <= '0;
         write_en_reg     <= 1'b0;
         wr_data_reg      <= '0;
         read_en_reg      <= 1'b0;
         busy_reg         <= 1'b0;
         frame_err_reg    <= 1'b0;
      end else begin
         write_en_reg  <= 1'b0;
         read_en_reg   <= 1'b0;
         frame_err_reg <= 1'b0;
         if (incr_pending_reg) begin
            address_reg      <= address_reg + ADDR_W'(1);
            incr_pending_reg <= 1'b0;
         end

         if (cs_rise && state_reg != WAIT_IDLE && state_reg != IDLE) begin
            if (partial)
               frame_err_reg <= 1'b1;
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
            miso_reg    <= 1'b1;
            bit_cnt_reg <= '0;
         end else begin
            case (state_reg)
               WAIT_IDLE: begin
                  if (cs_high)
                     state_reg <= IDLE;
               end
               IDLE: begin
                  miso_reg <= 1'b1;
                  if (cs_fall) begin
                     state_reg   <= HEADER;
                     bit_cnt_reg <= '0;
                     busy_reg    <= 1'b1;
                  end
               end
               HEADER: begin
                  if (sclk_rise) begin
                     shift_in_reg <= {shift_in_reg[SH_W-3:0], mosi_s};
                     if (bit_cnt_reg == HDR_LAST) begin
                        bit_cnt_reg <= '0;
                        if (!hdr_ok) begin
                           frame_err_reg <= 1'b1;
                           state_reg     <= ERROR;
                        end else begin
                           address_reg <= hdr_word[ADDR_W-1:0];
                           if (hdr_word[HDR_W-1]) begin
                              read_en_reg <= 1'b1;
                              lat_cnt_reg <= '0;
                              state_reg   <= RFETCH;
                           end else begin
                              state_reg <= WDATA;
                           end
                        end
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                     end
                  end
               end
               WDATA: begin
                  if (sclk_rise) begin
                     shift_in_reg <= {shift_in_reg[SH_W-3:0], mosi_s};
                     if (bit_cnt_reg == DATA_LAST) begin
                        bit_cnt_reg      <= '0;
                        write_en_reg     <= 1'b1;
                        wr_data_reg      <= data_word;
                        incr_pending_reg <= 1'b1;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                     end
                  end
               end
               // rd_data is sampled RD_LAT clocks after the cycle read_en was high.
               RFETCH: begin
                  if (lat_cnt_reg == LAT_LAST) begin
                     shift_out_reg <= rd_data;
                     bit_seen_reg  <= 1'b0;
                     bit_cnt_reg   <= '0;
                     state_reg     <= RDATA;
                  end else begin
                     lat_cnt_reg <= lat_cnt_reg + 2'd1;
                  end
               end
               RDATA: begin
                  if (sclk_rise) begin
                     bit_seen_reg <= 1'b1;
                     if (bit_cnt_reg == DATA_LAST) begin
                        bit_cnt_reg <= '0;
                        address_reg <= address_reg + ADDR_W'(1);
                        read_en_reg <= 1'b1;
                        lat_cnt_reg <= '0;
                        state_reg   <= RFETCH;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                     end
                  end else if (sclk_fall) begin
                     // The first fall after a load presents the MSB; later falls advance one bit.
                     bit_seen_reg <= 1'b0;
                     if (bit_seen_reg) begin
                        miso_reg      <= shift_out_reg[DATA_W-2];
                        shift_out_reg <= {shift_out_reg[DATA_W-2:0], 1'b0};
                     end else begin
                        miso_reg <= shift_out_reg[DATA_W-1];
                     end
                  end
               end
               ERROR: begin
                  miso_reg <= 1'b1;
               end
               default: begin
                  state_reg <= WAIT_IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n)
         err_count_reg <= '0;
      else if (frame_err_reg && err_count_reg != 8'hFF)
         err_count_reg <= err_count_reg + 8'd1;
   end

   assign miso      = miso_reg;
   assign address   = address_reg;
   assign write_en  = write_en_reg;
   assign wr_data   = wr_data_reg;
   assign read_en   = read_en_reg;
   assign busy      = busy_reg;
   assign frame_err = frame_err_reg;
   assign err_count = err_count_reg;

endmodule

// File: tb/tb_spi_target_burst.sv
// Bench for spi_target_burst: bit-banged SPI host, register-file model and strobe scoreboard.
`timescale 1ns/1ps
module tb_spi_target_burst;

   localparam int HALF = 100;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       spi_clk = 1'b0;
   logic       cs_n = 1'b1;
   logic       mosi = 1'b0;
   logic       miso;
   logic [5:0] address;
   logic       write_en;
   logic [7:0] wr_data;
   logic       read_en;
   logic [7:0] rd_data = 8'h00;
   logic       busy;
   logic       frame_err;
   logic [7:0] err_count;

   int checks = 0;
   int errors = 0;
   int fe_pulses = 0;
   int strobe_viol = 0;
   logic prev_we = 1'b0;
   logic prev_re = 1'b0;

   logic [7:0] mem [64];
   logic [5:0] exp_wr_addr[$];
   logic [7:0] exp_wr_data[$];
   logic [5:0] obs_wr_addr[$];
   logic [7:0] obs_wr_data[$];
   logic [5:0] exp_rd_addr[$];
   logic [5:0] obs_rd_addr[$];
   logic [7:0] exp_rx[$];

   spi_target_burst dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .spi_clk   (spi_clk),
      .cs_n      (cs_n),
      .mosi      (mosi),
      .miso      (miso),
      .address   (address),
      .write_en  (write_en),
      .wr_data   (wr_data),
      .read_en   (read_en),
      .rd_data   (rd_data),
      .busy      (busy),
      .frame_err (frame_err),
      .err_count (err_count)
   );

   always #5 clock = ~clock;

   // Register file with one clock of read latency.
   always @(posedge clock) if (read_en) rd_data <= mem[address];

   always @(negedge clock) begin
      if (write_en) begin
         obs_wr_addr.push_back(address);
         obs_wr_data.push_back(wr_data);
         $display("write strobe addr=%02h data=%02h", address, wr_data);
      end
      if (read_en) begin
         obs_rd_addr.push_back(address);
         $display("read strobe addr=%02h", address);
      end
      if (frame_err) begin
         fe_pulses++;
         $display("frame_err pulse err_count=%0d", err_count);
      end
      if ((write_en && read_en) || (write_en && prev_we) || (read_en && prev_re))
         strobe_viol++;
      prev_we = write_en;
      prev_re = read_en;
   end

   function automatic logic [7:0] make_hdr(input logic rw, input logic [5:0] a, input logic flip);
      logic par;
      par = (^{rw, a}) ^ flip;
      return {rw, par, a};
   endfunction

   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < n; i++) begin
         mosi = tx[7-i];
         #HALF;
         spi_clk = 1'b1;
         rx[7-i] = miso;
         #HALF;
         spi_clk = 1'b0;
      end
   endtask

   task automatic cs_start;
      cs_n = 1'b0;
      #HALF;
   endtask

   task automatic cs_end;
      #HALF;
      cs_n = 1'b1;
      #(4*HALF);
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      checks++; if (miso !== 1'b1) begin errors++; $display("FAIL reset_miso got=%b exp=1", miso); end
      checks++; if (address !== 6'h00) begin errors++; $display("FAIL reset_address got=%02h exp=00", address); end
      checks++; if (write_en !== 1'b0 || read_en !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%b%b exp=00", write_en, read_en); end
      checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got=%02h exp=00", wr_data); end
      checks++; if (busy !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL reset_busy_err got=%b%b exp=00", busy, frame_err); end
      checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
      reset_n = 1'b1;
      repeat (10) @(posedge clock);
   endtask

   task automatic test_write_single;
      logic [7:0] rx;
      logic [5:0] a;
      logic [7:0] d;
      exp_wr_addr.push_back(6'h05); exp_wr_data.push_back(8'hA5);
      cs_start;
      spi_bits(make_hdr(1'b0, 6'h05, 1'b0), 8, rx);
      spi_bits(8'hA5, 8, rx);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write1_busy got=%b exp=1", busy); end
      cs_end;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write1_busy_end got=%b exp=0", busy); end
      checks++; if (obs_wr_addr.size() != exp_wr_addr.size()) begin errors++; $display("FAIL write1_count got=%0d exp=%0d", obs_wr_addr.size(), exp_wr_addr.size()); end
      while (exp_wr_addr.size() > 0 && obs_wr_addr.size() > 0) begin
         a = exp_wr_addr.pop_front(); d = exp_wr_data.pop_front();
         checks++; if (obs_wr_addr[0] !== a || obs_wr_data[0] !== d) begin errors++; $display("FAIL write1_data got=%02h/%02h exp=%02h/%02h", obs_wr_addr[0], obs_wr_data[0], a, d); end
         void'(obs_wr_addr.pop_front()); void'(obs_wr_data.pop_front());
      end
      exp_wr_addr.delete(); exp_wr_data.delete(); obs_wr_addr.delete(); obs_wr_data.delete();
   endtask

   task automatic test_burst_wrap;
      logic [7:0] rx;
      logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
      logic [5:0] addrs [3] = '{6'h3F, 6'h00, 6'h01};
      logic [5:0] a;
      logic [7:0] d;
      cs_start;
      spi_bits(make_hdr(1'b0, 6'h3F, 1'b0), 8, rx);
      for (int i = 0; i < 3; i++) begin
         exp_wr_addr.push_back(addrs[i]); exp_wr_data.push_back(words[i]);
         spi_bits(words[i], 8, rx);
      end
      cs_end;
      checks++; if (obs_wr_addr.size() != 3) begin errors++; $display("FAIL burst_count got=%0d exp=3", obs_wr_addr.size()); end
      while (exp_wr_addr.size() > 0 && obs_wr_addr.size() > 0) begin
         a = exp_wr_addr.pop_front(); d = exp_wr_data.pop_front();
         checks++; if (obs_wr_addr[0] !== a || obs_wr_data[0] !== d) begin errors++; $display("FAIL burst_data got=%02h/%02h exp=%02h/%02h", obs_wr_addr[0], obs_wr_data[0], a, d); end
         void'(obs_wr_addr.pop_front()); void'(obs_wr_data.pop_front());
      end
      exp_wr_addr.delete(); exp_wr_data.delete(); obs_wr_addr.delete(); obs_wr_data.delete();
   endtask

   task automatic test_read;
      logic [7:0] rx;
      logic [7:0] e;
      logic [5:0] a;
      mem[6'h12] = 8'hC3;
      mem[6'h13] = 8'h5A;
      exp_rd_addr.push_back(6'h12); exp_rd_addr.push_back(6'h13); exp_rd_addr.push_back(6'h14);
      exp_rx.push_back(8'hC3); exp_rx.push_back(8'h5A);
      cs_start;
      spi_bits(make_hdr(1'b1, 6'h12, 1'b0), 8, rx);
      for (int i = 0; i < 2; i++) begin
         spi_bits(8'h00, 8, rx);
         e = exp_rx.pop_front();
         $display("read word %0d miso=%02h", i, rx);
         checks++; if (rx !== e) begin errors++; $display("FAIL read_miso word=%0d got=%02h exp=%02h", i, rx, e); end
      end
      cs_end;
      checks++; if (obs_rd_addr.size() != 3) begin errors++; $display("FAIL read_strobe_count got=%0d exp=3", obs_rd_addr.size()); end
      while (exp_rd_addr.size() > 0 && obs_rd_addr.size() > 0) begin
         a = exp_rd_addr.pop_front();
         checks++; if (obs_rd_addr[0] !== a) begin errors++; $display("FAIL read_addr got=%02h exp=%02h", obs_rd_addr[0], a); end
         void'(obs_rd_addr.pop_front());
      end
      checks++; if (obs_wr_addr.size() != 0) begin errors++; $display("FAIL read_no_write got=%0d exp=0", obs_wr_addr.size()); end
      checks++; if (miso !== 1'b1) begin errors++; $display("FAIL read_miso_idle got=%b exp=1", miso); end
      exp_rd_addr.delete(); obs_rd_addr.delete(); obs_wr_addr.delete(); obs_wr_data.delete();
   endtask

   task automatic test_bad_parity;
      logic [7:0] rx;
      int fe0;
      fe0 = fe_pulses;
      cs_start;
      spi_bits(make_hdr(1'b0, 6'h05, 1'b1), 8, rx);
      spi_bits(8'h3C, 8, rx);
      cs_end;
      checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL badpar_miso got=%02h exp=ff", rx); end
      checks++; if (obs_wr_addr.size() != 0 || obs_rd_addr.size() != 0) begin errors++; $display("FAIL badpar_strobes got=%0d/%0d exp=0/0", obs_wr_addr.size(), obs_rd_addr.size()); end
      checks++; if (fe_pulses - fe0 != 1) begin errors++; $display("FAIL badpar_frame_err got=%0d exp=1", fe_pulses - fe0); end
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL badpar_err_count got=%0d exp=1", err_count); end
      obs_wr_addr.delete(); obs_wr_data.delete(); obs_rd_addr.delete();
   endtask

   task automatic test_partial_write;
      logic [7:0] rx;
      int fe0;
      logic [5:0] a;
      logic [7:0] d;
      fe0 = fe_pulses;
      cs_start;
      spi_bits(make_hdr(1'b0, 6'h07, 1'b0), 8, rx);
      spi_bits(8'hF0, 4, rx);
      cs_end;
      checks++; if (obs_wr_addr.size() != 0) begin errors++; $display("FAIL partial_no_write got=%0d exp=0", obs_wr_addr.size()); end
      checks++; if (fe_pulses - fe0 != 1) begin errors++; $display("FAIL partial_frame_err got=%0d exp=1", fe_pulses - fe0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_busy got=%b exp=0", busy); end
      checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL partial_err_count got=%0d exp=2", err_count); end
      exp_wr_addr.push_back(6'h08); exp_wr_data.push_back(8'h3C);
      cs_start;
      spi_bits(make_hdr(1'b0, 6'h08, 1'b0), 8, rx);
      spi_bits(8'h3C, 8, rx);
      cs_end;
      checks++; if (obs_wr_addr.size() != 1) begin errors++; $display("FAIL partial_next_count got=%0d exp=1", obs_wr_addr.size()); end
      while (exp_wr_addr.size() > 0 && obs_wr_addr.size() > 0) begin
         a = exp_wr_addr.pop_front(); d = exp_wr_data.pop_front();
         checks++; if (obs_wr_addr[0] !== a || obs_wr_data[0] !== d) begin errors++; $display("FAIL partial_next_data got=%02h/%02h exp=%02h/%02h", obs_wr_addr[0], obs_wr_data[0], a, d); end
         void'(obs_wr_addr.pop_front()); void'(obs_wr_data.pop_front());
      end
      exp_wr_addr.delete(); exp_wr_data.delete(); obs_wr_addr.delete(); obs_wr_data.delete();
   endtask

   task automatic test_reset_mid_burst;
      logic [7:0] rx;
      int fe0;
      logic [5:0] a;
      logic [7:0] d;
      exp_wr_addr.push_back(6'h10); exp_wr_data.push_back(8'h99);
      cs_start;
      spi_bits(make_hdr(1'b0, 6'h10, 1'b0), 8, rx);
      spi_bits(8'h99, 8, rx);
      spi_bits(8'h66, 4, rx);
      @(posedge clock);
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (write_en !== 1'b0 || busy !== 1'b0 || miso !== 1'b1) begin errors++; $display("FAIL midrst_outputs got=we%b busy%b miso%b exp=we0 busy0 miso1", write_en, busy, miso); end
      checks++; if (err_count !== 8'd0 || address !== 6'h00) begin errors++; $display("FAIL midrst_regs got=%0d/%02h exp=0/00", err_count, address); end
      reset_n = 1'b1;
      fe0 = fe_pulses;
      spi_bits(8'h60, 4, rx);
      spi_bits(8'h5A, 8, rx);
      cs_end;
      checks++; if (obs_wr_addr.size() != 1 || obs_rd_addr.size() != 0) begin errors++; $display("FAIL midrst_strobes got=%0d/%0d exp=1/0", obs_wr_addr.size(), obs_rd_addr.size()); end
      checks++; if (fe_pulses != fe0) begin errors++; $display("FAIL midrst_frame_err got=%0d exp=0", fe_pulses - fe0); end
      exp_wr_addr.push_back(6'h20); exp_wr_data.push_back(8'h77);
      cs_start;
      spi_bits(make_hdr(1'b0, 6'h20, 1'b0), 8, rx);
      spi_bits(8'h77, 8, rx);
      cs_end;
      checks++; if (obs_wr_addr.size() != 2) begin errors++; $display("FAIL midrst_total got=%0d exp=2", obs_wr_addr.size()); end
      while (exp_wr_addr.size() > 0 && obs_wr_addr.size() > 0) begin
         a = exp_wr_addr.pop_front(); d = exp_wr_data.pop_front();
         checks++; if (obs_wr_addr[0] !== a || obs_wr_data[0] !== d) begin errors++; $display("FAIL midrst_data got=%02h/%02h exp=%02h/%02h", obs_wr_addr[0], obs_wr_data[0], a, d); end
         void'(obs_wr_addr.pop_front()); void'(obs_wr_data.pop_front());
      end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL midrst_err_count got=%0d exp=0", err_count); end
      exp_wr_addr.delete(); exp_wr_data.delete(); obs_wr_addr.delete(); obs_wr_data.delete(); obs_rd_addr.delete();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 8'(i * 3);
      test_reset;
      test_write_single;
      test_burst_wrap;
      test_read;
      test_bad_parity;
      test_partial_write;
      test_reset_mid_burst;
      checks++; if (strobe_viol != 0) begin errors++; $display("FAIL strobe_shape got=%0d exp=0", strobe_viol); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
